// File: rtl/ahb_sram_pkg.sv
// ahb_sram_pkg: shared types and constants for the AHB-Lite to SRAM bridge
package ahb_sram_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RDLAT,
        ST_ERR1,
        ST_ERR2
    } state_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_sram_be_gen.sv
// ahb_sram_be_gen: little-endian byte enables and misaligned/oversize flag from HSIZE and address low bits
module ahb_sram_be_gen
    import ahb_sram_pkg::*;
#(
    parameter  int DBITS = 32,
    localparam int BW    = DBITS / 8,
    localparam int OFS   = $clog2(BW)
) (
    input  logic [2:0]     hsize_i,
    input  logic [OFS-1:0] addr_i,
    output logic [BW-1:0]  be_o,
    output logic           bad_o
);

    // A lane is enabled when it shares the naturally aligned chunk of the address
    always_comb begin
        bad_o = (hsize_i > 3'(OFS)) || ((addr_i & OFS'((32'd1 << hsize_i) - 32'd1)) != '0);
        be_o  = '0;
        for (int i = 0; i < BW; i++)
            be_o[i] = !bad_o && ((OFS'(i) >> hsize_i) == (addr_i >> hsize_i));
    end

endmodule

// File: rtl/ahb_sram_bridge.sv
// ahb_sram_bridge: AHB-Lite slave driving a single-port synchronous SRAM; AHB_SRAM_RESP_ERR_EN enables ERROR responses for bad transfers
module ahb_sram_bridge
    import ahb_sram_pkg::*;
#(
    parameter  int ABITS = 10,
    parameter  int DBITS = 32,
    localparam int BW    = DBITS / 8,
    localparam int OFS   = $clog2(BW)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hsel_i,
    input  logic [31:0]      haddr_i,
    input  logic [1:0]       htrans_i,
    input  logic             hwrite_i,
    input  logic [2:0]       hsize_i,
    input  logic             hready_i,
    input  logic [DBITS-1:0] hwdata_i,
    output logic [DBITS-1:0] hrdata_o,
    output logic             hreadyout_o,
    output logic             hresp_o,
    output logic [ABITS-1:0] mem_addr_o,
    output logic             mem_we_o,
    output logic [BW-1:0]    mem_be_o,
    output logic [DBITS-1:0] mem_din_o,
    input  logic [DBITS-1:0] mem_dout_i
);

    if (DBITS != 32 && DBITS != 64) begin : g_bad_dbits
        $error("ahb_sram_bridge: DBITS must be 32 or 64");
    end

    state_e           state_q, state_d;
    logic [ABITS-1:0] addr_q, addr_d, maddr_q, hword;
    logic [BW-1:0]    be_q, be_d, be;
    logic             wen_q, wen_d, bad, acc, unused_ok;
    logic [DBITS-1:0] din_q;

    assign hword     = haddr_i[ABITS+OFS-1:OFS];
    assign unused_ok = ^haddr_i[31:ABITS+OFS];
    assign acc       = hsel_i && hready_i && (htrans_i == HT_NONSEQ || htrans_i == HT_SEQ);

    ahb_sram_be_gen #(.DBITS(DBITS)) u_be_gen (
        .hsize_i (hsize_i),
        .addr_i  (haddr_i[OFS-1:0]),
        .be_o    (be),
        .bad_o   (bad)
    );

    assign hreadyout_o = !(state_q == ST_RDLAT || state_q == ST_ERR1);
    assign hresp_o     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata_o    = state_q == ST_READ ? mem_dout_i : '0;
    assign mem_we_o    = state_q == ST_WRITE && wen_q;
    assign mem_be_o    = state_q == ST_WRITE ? be_q : '0;
    assign mem_din_o   = state_q == ST_WRITE ? hwdata_i : din_q;

    // Next state and SRAM address; a read behind a write is replayed from addr_q in ST_RDLAT
    always_comb begin
        state_d    = ST_IDLE;
        addr_d     = addr_q;
        be_d       = be_q;
        wen_d      = wen_q;
        mem_addr_o = maddr_q;
        if (state_q == ST_RDLAT) begin
            state_d    = ST_READ;
            mem_addr_o = addr_q;
        end else if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else begin
            if (state_q == ST_WRITE)
                mem_addr_o = addr_q;
            if (acc) begin
`ifdef AHB_SRAM_RESP_ERR_EN
                if (bad)
                    state_d = ST_ERR1;
                else
`endif
                if (hwrite_i) begin
                    state_d = ST_WRITE;
                    addr_d  = hword;
                    be_d    = be;
                    wen_d   = !bad;
                end else if (state_q == ST_WRITE) begin
                    state_d = ST_RDLAT;
                    addr_d  = hword;
                end else begin
                    state_d    = ST_READ;
                    mem_addr_o = hword;
                end
            end
        end
    end

    // State and held SRAM address/data registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wen_q   <= 1'b0;
            maddr_q <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wen_q   <= wen_d;
            maddr_q <= mem_addr_o;
            din_q   <= mem_din_o;
        end
    end

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// tb_ahb_sram_bridge: cycle-table bench with SRAM model and read-data scoreboard for ahb_sram_bridge
module tb_ahb_sram_bridge;
    import ahb_sram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1, hsel_i = 1'b0, hwrite_i = 1'b0, hready_i;
    logic [31:0] haddr_i = '0, hwdata_i = '0, hrdata_o, mem_din_o, mem_dout_i;
    logic [1:0]  htrans_i = HT_IDLE;
    logic [2:0]  hsize_i = HSIZE_WORD;
    logic        hreadyout_o, hresp_o, mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem [1024];

    int checks = 0, errors = 0;
    logic [31:0] sb [$];
    logic pend = 1'b0;

    typedef struct {
        logic        rst, sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        rdy, resp, we;
        logic [3:0]  be;
        logic [31:0] rexp;
    } row_t;
    row_t vec [$];

    always #5 clk = ~clk;
    assign hready_i = hreadyout_o;

    ahb_sram_bridge #(.ABITS(10), .DBITS(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .hsel_i(hsel_i), .haddr_i(haddr_i), .htrans_i(htrans_i),
        .hwrite_i(hwrite_i), .hsize_i(hsize_i), .hready_i(hready_i), .hwdata_i(hwdata_i),
        .hrdata_o(hrdata_o), .hreadyout_o(hreadyout_o), .hresp_o(hresp_o), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_din_o(mem_din_o), .mem_dout_i(mem_dout_i)
    );

    // Single-port SRAM with one-cycle registered read
    always @(posedge clk) begin
        if (mem_we_o)
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) mem[mem_addr_o][b*8 +: 8] <= mem_din_o[b*8 +: 8];
        mem_dout_i <= mem[mem_addr_o];
    end

    function automatic row_t mk(logic rst, logic sel, logic [1:0] trans, logic wr, logic [31:0] addr,
                                logic [2:0] size, logic [31:0] wdata, logic rdy, logic resp, logic we,
                                logic [3:0] be, logic [31:0] rexp);
        row_t r;
        r.rst = rst; r.sel = sel; r.trans = trans; r.wr = wr; r.addr = addr; r.size = size;
        r.wdata = wdata; r.rdy = rdy; r.resp = resp; r.we = we; r.be = be; r.rexp = rexp;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, check at negedge, track accepted reads in the scoreboard
    task automatic step(input string tag, input row_t r);
        rst_i = r.rst; hsel_i = r.sel; htrans_i = r.trans; hwrite_i = r.wr;
        haddr_i = r.addr; hsize_i = r.size; hwdata_i = r.wdata;
        @(negedge clk);
        chk({tag, " hreadyout"}, 32'(hreadyout_o), 32'(r.rdy));
        chk({tag, " hresp"}, 32'(hresp_o), 32'(r.resp));
        chk({tag, " mem_we"}, 32'(mem_we_o), 32'(r.we));
        chk({tag, " mem_be"}, 32'(mem_be_o), 32'(r.be));
        if (pend && hreadyout_o) begin
            if (sb.size() == 0) chk({tag, " scoreboard_empty"}, 32'd0, 32'd1);
            else chk({tag, " hrdata"}, hrdata_o, sb.pop_front());
            pend = 1'b0;
        end else begin
            chk({tag, " hrdata_zero"}, hrdata_o, 32'd0);
        end
        if (hreadyout_o && r.sel && r.trans[1] && !r.wr) begin
            sb.push_back(r.rexp);
            pend = 1'b1;
        end
        if (r.rst) begin
            sb.delete();
            pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'hA500_0000 | 32'(k);
        // trans, wr, addr, size, wdata | rdy, resp, we, be, rexp
        vec.push_back(mk(0, 1, HT_IDLE,   0, 32'h000, 2, 32'h0,        1, 0, 0, 4'h0, 0));
        vec.push_back(mk(0, 1, HT_NONSEQ, 1, 32'h004, 2, 32'h0,        1, 0, 0, 4'h0, 0));
        vec.push_back(mk(0, 1, HT_IDLE,   0, 32'h000, 2, 32'hDEADBEEF, 1, 0, 1, 4'hF, 0));
        vec.push_back(mk(0, 1, HT_NONSEQ, 0, 32'h004, 2, 32'h0,        1, 0, 0, 4'h0, 32'hDEADBEEF));
        vec.push_back(mk(0, 1, HT_NONSEQ, 1, 32'h006, 0, 32'h0,        1, 0, 0, 4'h0, 0));
        vec.push_back(mk(0, 1, HT_NONSEQ, 0, 32'h004, 2, 32'h00AB0000, 1, 0, 1, 4'h4, 32'hDEABBEEF));
        vec.push_back(mk(0, 1, HT_NONSEQ, 0, 32'h004, 2, 32'h0,        0, 0, 0, 4'h0, 0));
        vec.push_back(mk(0, 1, HT_IDLE,   0, 32'h000, 2, 32'h0,        1, 0, 0, 4'h0, 0));
        vec.push_back(mk(0, 1, HT_NONSEQ, 1, 32'h010, 2, 32'h0,        1, 0, 0, 4'h0, 0));
        vec.push_back(mk(0, 1, HT_NONSEQ, 0, 32'h010, 2, 32'h11111111, 1, 0, 1, 4'hF, 32'h11111111));
        vec.push_back(mk(0, 1, HT_NONSEQ, 0, 32'h010, 2, 32'h0,        0, 0, 0, 4'h0, 0));
        vec.push_back(mk(0, 1, HT_NONSEQ, 0, 32'h000, 2, 32'h0,        1, 0, 0, 4'h0, 32'hA5000000));
        vec.push_back(mk(0, 1, HT_SEQ,    0, 32'h004, 2, 32'h0,        1, 0, 0, 4'h0, 32'hDEABBEEF));
        vec.push_back(mk(0, 1, HT_SEQ,    0, 32'h008, 2, 32'h0,        1, 0, 0, 4'h0, 32'hA5000002));
        vec.push_back(mk(0, 1, HT_IDLE,   0, 32'h000, 2, 32'h0,        1, 0, 0, 4'h0, 0));
        vec.push_back(mk(0, 1, HT_BUSY,   1, 32'h004, 2, 32'h0,        1, 0, 0, 4'h0, 0));
        vec.push_back(mk(0, 0, HT_NONSEQ, 1, 32'h004, 2, 32'h0,        1, 0, 0, 4'h0, 0));
        vec.push_back(mk(0, 1, HT_IDLE,   0, 32'h000, 2, 32'hFFFFFFFF, 1, 0, 0, 4'h0, 0));
        vec.push_back(mk(0, 1, HT_NONSEQ, 1, 32'h002, 2, 32'h0,        1, 0, 0, 4'h0, 0));
`ifdef AHB_SRAM_RESP_ERR_EN
        vec.push_back(mk(0, 1, HT_IDLE,   0, 32'h000, 2, 32'h12345678, 0, 1, 0, 4'h0, 0));
        vec.push_back(mk(0, 1, HT_IDLE,   0, 32'h000, 2, 32'h0,        1, 1, 0, 4'h0, 0));
`else
        vec.push_back(mk(0, 1, HT_IDLE,   0, 32'h000, 2, 32'h12345678, 1, 0, 0, 4'h0, 0));
`endif
        vec.push_back(mk(0, 1, HT_NONSEQ, 0, 32'h000, 2, 32'h0,        1, 0, 0, 4'h0, 32'hA5000000));
        vec.push_back(mk(0, 1, HT_IDLE,   0, 32'h000, 2, 32'h0,        1, 0, 0, 4'h0, 0));

        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("reset hreadyout", 32'(hreadyout_o), 32'd1);
        chk("reset hresp", 32'(hresp_o), 32'd0);
        chk("reset hrdata", hrdata_o, 32'd0);
        chk("reset mem_we", 32'(mem_we_o), 32'd0);
        chk("reset mem_be", 32'(mem_be_o), 32'd0);
        chk("reset mem_addr", 32'(mem_addr_o), 32'd0);
        chk("reset mem_din", mem_din_o, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vec.size(); i++) step($sformatf("row%0d", i), vec[i]);

        step("rst_a", mk(0, 1, HT_NONSEQ, 1, 32'h020, 2, 32'h0,        1, 0, 0, 4'h0, 0));
        step("rst_b", mk(0, 1, HT_NONSEQ, 0, 32'h010, 2, 32'h00000055, 1, 0, 1, 4'hF, 32'h11111111));
        step("rst_c", mk(1, 1, HT_NONSEQ, 0, 32'h010, 2, 32'h0,        0, 0, 0, 4'h0, 0));
        step("rst_d", mk(0, 1, HT_IDLE,   0, 32'h000, 2, 32'h0,        1, 0, 0, 4'h0, 0));
        chk("rst mem_addr", 32'(mem_addr_o), 32'd0);
        chk("rst mem_din", mem_din_o, 32'd0);
        step("rst_e", mk(0, 1, HT_NONSEQ, 0, 32'h010, 2, 32'h0,        1, 0, 0, 4'h0, 32'h11111111));
        step("rst_f", mk(0, 1, HT_NONSEQ, 0, 32'h020, 2, 32'h0,        1, 0, 0, 4'h0, 32'h00000055));
        step("rst_g", mk(0, 1, HT_IDLE,   0, 32'h000, 2, 32'h0,        1, 0, 0, 4'h0, 0));
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
